// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and encodings for the memory pipeline stage.
package mem_stage_pkg;

    localparam int STALL_W_DEF  = 6;
    localparam int EX_MEM_W_DEF = 147;
    localparam int MEM_WB_W_DEF = 136;

    localparam int  STALL_MEM = 3;
    localparam int  STALL_WB  = 4;
    localparam logic STOP     = 1'b1;
    localparam logic NO_STOP  = 1'b0;

    // One-hot mem_op bit positions
    localparam int OP_LB  = 4;
    localparam int OP_LBU = 3;
    localparam int OP_LH  = 2;
    localparam int OP_LHU = 1;
    localparam int OP_LW  = 0;

    typedef struct packed {
        logic [65:0] hilo_bus;
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef struct packed {
        logic [65:0] hilo_bus;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_wb_t;

    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks byte/halfword/word and extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  mem_op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] load_result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[7:0];
        case (off_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
        half_sel = off_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        load_result_o = 32'd0;
        if (mem_op_i[OP_LB])
            load_result_o = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op_i[OP_LBU])
            load_result_o = {24'd0, byte_sel};
        else if (mem_op_i[OP_LH])
            load_result_o = {{16{half_sel[15]}}, half_sel};
        else if (mem_op_i[OP_LHU])
            load_result_o = {16'd0, half_sel};
        else if (mem_op_i[OP_LW])
            load_result_o = data_i;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bus, keeps SRAM read data alive
// across stalls, aligns loads and selects the write-back value.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_W  = STALL_W_DEF,
    parameter int EX_MEM_W = EX_MEM_W_DEF,
    parameter int MEM_WB_W = MEM_WB_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [STALL_W-1:0]  stall,
    input  logic [EX_MEM_W-1:0] ex_to_mem_bus,
    input  logic [31:0]         data_sram_rdata,
    output logic [MEM_WB_W-1:0] mem_to_wb_bus,
    output logic [37:0]         mem_to_rf_bus,
    output logic                stallreq_for_mem
);

    ex_mem_t     bus_q, bus_d;
    hold_state_e state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] load_data;
    logic [31:0] load_result;
    mem_wb_t     wb;
    logic        unused_bits;

    always_comb begin
        bus_d = bus_q;
        if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP)
            bus_d = '0;
        else if (stall[STALL_MEM] == NO_STOP)
            bus_d = ex_to_mem_bus;
    end

    // SRAM data is only valid the cycle after the request, so snapshot it
    // the first time a load gets stuck here and keep it until we advance.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            FRESH: begin
                if (stall[STALL_MEM] == STOP && bus_q.data_ram_en) begin
                    state_d = HELD;
                    hold_d  = data_sram_rdata;
                end
            end
            HELD: begin
                if (stall[STALL_MEM] == NO_STOP)
                    state_d = FRESH;
            end
            default: state_d = FRESH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q   <= '0;
            state_q <= FRESH;
            hold_q  <= 32'd0;
        end else begin
            bus_q   <= bus_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign load_data = (state_q == HELD) ? hold_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .mem_op_i      (bus_q.mem_op),
        .off_i         (bus_q.ex_result[1:0]),
        .data_i        (load_data),
        .load_result_o (load_result)
    );

    always_comb begin
        wb.hilo_bus = bus_q.hilo_bus;
        wb.pc       = bus_q.pc;
        wb.rf_we    = bus_q.rf_we;
        wb.rf_waddr = bus_q.rf_waddr;
        wb.rf_wdata = bus_q.sel_rf_res ? load_result : bus_q.ex_result;
    end

    assign mem_to_wb_bus    = wb;
    assign mem_to_rf_bus    = {wb.rf_we, wb.rf_waddr, wb.rf_wdata};
    assign stallreq_for_mem = NO_STOP;

    assign unused_bits = ^{stall[2:0], stall[STALL_W-1:5], bus_q.data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, stall hold, bubble, reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk;
    logic         resetn;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [37:0]  mem_to_rf_bus;
    logic         stallreq_for_mem;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_MW   = 6'b011000;
    localparam logic [5:0] ST_BUB  = 6'b001000;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_rf_bus    (mem_to_rf_bus),
        .stallreq_for_mem (stallreq_for_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [146:0] mk(input logic [65:0] hilo, input logic [4:0] op,
                                        input logic [31:0] pc, input logic en,
                                        input logic sel, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] res);
        ex_mem_t b;
        assert ($onehot0(op)) else $fatal(1, "illegal multi-hot mem_op %b", op);
        b.hilo_bus     = hilo;
        b.mem_op       = op;
        b.pc           = pc;
        b.data_ram_en  = en;
        b.data_ram_wen = 4'd0;
        b.sel_rf_res   = sel;
        b.rf_we        = we;
        b.rf_waddr     = waddr;
        b.ex_result    = res;
        return b;
    endfunction

    function automatic logic [135:0] wbv(input logic [65:0] hilo, input logic [31:0] pc,
                                         input logic we, input logic [4:0] waddr,
                                         input logic [31:0] wdata);
        return {hilo, pc, we, waddr, wdata};
    endfunction

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
        $display("check %-12s observed %0h expected %0h", tag, obs, expv);
    endtask

    // Present next bus / stall plus the rdata answering the load already registered
    task automatic cyc(input logic [146:0] bus, input logic [5:0] st, input logic [31:0] rd);
        @(negedge clk);
        ex_to_mem_bus   = bus;
        stall           = st;
        data_sram_rdata = rd;
        #1;
    endtask

    logic [65:0]  hz, hilo_a;
    logic [146:0] b_lb, b_lbu, b_lh, b_lhu, b_lw1, b_nop, b_lb0, b_lwa, b_lwb, b_lwc, b_alu, b_alu2;

    initial begin
        hz     = '0;
        hilo_a = {1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002};
        b_lb   = mk(hz, 5'b10000, 32'hBFC0_0000, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1003);
        b_lbu  = mk(hz, 5'b01000, 32'hBFC0_0004, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_1003);
        b_lh   = mk(hz, 5'b00100, 32'hBFC0_0008, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_1002);
        b_lhu  = mk(hz, 5'b00010, 32'hBFC0_000C, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_1000);
        b_lw1  = mk(hz, 5'b00001, 32'hBFC0_0010, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_1001);
        b_nop  = mk(hz, 5'b00000, 32'hBFC0_0014, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_1234);
        b_lb0  = mk(hz, 5'b10000, 32'hBFC0_0018, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_2000);
        b_lwa  = mk(hz, 5'b00001, 32'hBFC0_001C, 1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_3000);
        b_lwb  = mk(hz, 5'b00001, 32'hBFC0_0020, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_3004);
        b_lwc  = mk(hz, 5'b00001, 32'hBFC0_0024, 1'b1, 1'b1, 1'b1, 5'd13, 32'h0000_3008);
        b_alu  = mk(hilo_a, 5'b00000, 32'hBFC0_0028, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_002A);
        b_alu2 = mk(hilo_a, 5'b00000, 32'hBFC0_002C, 1'b0, 1'b0, 1'b1, 5'd17, 32'h0000_0099);

        resetn          = 1'b0;
        stall           = ST_NONE;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_wb", mem_to_wb_bus, '0);
        check("rst_rf", {98'd0, mem_to_rf_bus}, '0);
        check("stallreq", {135'd0, stallreq_for_mem}, '0);
        @(negedge clk);
        resetn = 1'b1;

        cyc(b_lb,  ST_NONE, 32'h0);
        cyc(b_lbu, ST_NONE, 32'h80FF_1234);
        check("lb_wb", mem_to_wb_bus, wbv(hz, 32'hBFC0_0000, 1'b1, 5'd3, 32'hFFFF_FF80));
        cyc(b_lh,  ST_NONE, 32'h80FF_1234);
        check("lbu", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'h0000_0080});
        cyc(b_lhu, ST_NONE, 32'h8001_7FFF);
        check("lh_off2", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'hFFFF_8001});
        cyc(b_lw1, ST_NONE, 32'h8001_7FFF);
        check("lhu_off0", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'h0000_7FFF});
        cyc(b_nop, ST_NONE, 32'hA5A5_A5A5);
        check("lw_off1", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'hA5A5_A5A5});
        cyc(b_lb0, ST_NONE, 32'hA5A5_A5A5);
        check("no_op_sel", {98'd0, mem_to_rf_bus}, {98'd0, 1'b1, 5'd9, 32'h0});
        cyc(b_lwa, ST_NONE, 32'h1234_567F);
        check("lb_off0", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'h0000_007F});

        // Load b_lwa is registered; stall it for three cycles while rdata changes
        cyc(b_lwb, ST_MW, 32'hDEAD_BEEF);
        check("stall_c1", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'hDEAD_BEEF});
        cyc(b_lwb, ST_MW, 32'h1111_1111);
        check("stall_c2", mem_to_wb_bus, wbv(hz, 32'hBFC0_001C, 1'b1, 5'd11, 32'hDEAD_BEEF));
        cyc(b_lwb, ST_MW, 32'h1111_1111);
        check("stall_c3", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'hDEAD_BEEF});
        cyc(b_lwb, ST_NONE, 32'h1111_1111);
        check("release", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'hDEAD_BEEF});
        cyc(b_lwc, ST_NONE, 32'h2222_3333);
        check("fresh_after", mem_to_wb_bus, wbv(hz, 32'hBFC0_0020, 1'b1, 5'd12, 32'h2222_3333));
        cyc(b_lwc, ST_MW, 32'h4444_5555);
        check("fresh_c1", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'h4444_5555});
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h6666_7777;
        #1;
        check("held_c2", {104'd0, mem_to_rf_bus[31:0]}, {104'd0, 32'h4444_5555});

        // Asynchronous reset while HELD
        resetn = 1'b0;
        #1;
        check("rst_mid_wb", mem_to_wb_bus, '0);
        check("rst_mid_rf", {98'd0, mem_to_rf_bus}, '0);
        check("rst_mid_hv", {135'd0, dut.state_q}, {135'd0, FRESH});
        @(negedge clk);
        resetn          = 1'b1;
        ex_to_mem_bus   = b_alu;
        stall           = ST_MW;
        data_sram_rdata = 32'h6666_6666;
        #1;
        cyc(b_alu, ST_NONE, 32'h6666_6666);
        check("rst_hold_wb", mem_to_wb_bus, '0);
        check("rst_hold_hv", {135'd0, dut.state_q}, {135'd0, FRESH});

        cyc(b_alu2, ST_NONE, 32'h0);
        check("alu_rf", {98'd0, mem_to_rf_bus}, {98'd0, 1'b1, 5'd5, 32'h0000_002A});
        check("alu_wb", mem_to_wb_bus, wbv(hilo_a, 32'hBFC0_0028, 1'b1, 5'd5, 32'h0000_002A));
        cyc(b_alu2, ST_BUB, 32'h0);
        check("pre_bubble", {98'd0, mem_to_rf_bus}, {98'd0, 1'b1, 5'd17, 32'h0000_0099});
        cyc(b_alu2, ST_NONE, 32'h0);
        check("bubble_wb", mem_to_wb_bus, '0);
        check("bubble_rf", {98'd0, mem_to_rf_bus}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute. Registers the execute-to-memory bus under stall control.
- Captures synchronous data-SRAM read data, which arrives exactly one cycle after the request issued in execute. Holds that data across memory-stage stalls so it is never lost.
- Aligns and extends load data, then selects the register write-back value.
- Drives the memory-to-write-back bus and the memory-stage forwarding bus back to decode.

Parameters:
- STALL_W, 6, width of the global stall vector; bit 3 = memory stage, bit 4 = write-back stage.
- EX_MEM_W, 147, execute-to-memory bus width (equals `EX_TO_MEM_WD).
- MEM_WB_W, 136, memory-to-write-back bus width (equals `MEM_TO_WB_WD).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  STALL_W  global stall vector from the stall controller.
- ex_to_mem_bus  in  EX_MEM_W  fields MSB to LSB: hilo_bus[65:0], mem_op[4:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0].
- data_sram_rdata  in  32  read data; valid only in the cycle after the request.
- mem_to_wb_bus  out  MEM_WB_W  fields: hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0].
- mem_to_rf_bus  out  38  forwarding: rf_we, rf_waddr[4:0], rf_wdata[31:0].
- stallreq_for_mem  out  1  tied to NoStop (0); reserved for future use.

Behaviour:
- Reset (resetn=0, asynchronous):
  - pipeline register, hold register and hold_valid all cleared to 0.
  - All outputs are therefore 0, so rf_we=0 and both hilo write enables are 0.
- Pipeline register update, on each rising clk edge, in priority order:
  - stall[3]=Stop and stall[4]=NoStop: load all-zero bubble.
  - stall[3]=NoStop: load ex_to_mem_bus.
  - otherwise: hold current contents.
- Read-data hold. One state bit, hold_valid; states FRESH (0) and HELD (1):
  - FRESH: the effective load data is data_sram_rdata, used combinationally.
  - FRESH to HELD: at a clock edge where stall[3]=Stop and the registered data_ram_en=1. On that edge hold_data captures data_sram_rdata.
  - HELD: the effective load data is hold_data. hold_data is not rewritten while HELD.
  - HELD to FRESH: at the first edge where stall[3]=NoStop, i.e. when a new instruction enters. This edge also covers the simultaneous case of leaving the stall while a new load enters: that load's data is read FRESH next cycle.
  - Reset mid-stall returns the block to FRESH with hold_data=0.
- mem_op one-hot, bit4..bit0 = lb, lbu, lh, lhu, lw. Byte offset off = ex_result[1:0]. Data is little-endian.
  - lb / lbu: byte off of the effective data (off=0 gives [7:0], off=3 gives [31:24]); sign- or zero-extend to 32 bits.
  - lh / lhu: halfword selected by off[1] (0 gives [15:0], 1 gives [31:16]); sign- or zero-extend. off[0] is ignored.
  - lw: effective data unchanged; off is ignored.
  - Misaligned accesses raise no exception.
  - mem_op=0 with sel_rf_res=1 yields 0.
  - More than one mem_op bit set is illegal. The design is not required to handle it; the bench asserts it never occurs.
- Write-back value: rf_wdata = sel_rf_res ? load_result : ex_result.
- Pass-through: rf_we, rf_waddr, pc and hilo_bus pass unchanged from the register.
- mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata}, driven from the same signals as mem_to_wb_bus.
- Latency: a bus accepted at edge N appears on the outputs in the cycle after edge N; rf_wdata for a load is valid in that same cycle.
- Outputs are combinational from registers plus data_sram_rdata; there is no other combinational input-to-output path.
- Writes are fully handled in execute; this stage ignores data_ram_wen beyond passing the register contents.

Decomposition:
- `EX_TO_MEM_WD, `MEM_TO_WB_WD, `StallBus, `Stop/`NoStop and the mem_op bit indices belong in lib/defines.vh.
- One natural sub-module, load_align: combinational; inputs mem_op, off, data; output load_result. It is reused if write-back ever takes over alignment.

Test Plan:
- Reset: assert resetn=0 mid-run -> all outputs 0 immediately, without waiting for a clock; hold_valid=0 afterwards.
- lb at ex_result=0x1003 with rdata=0x80FF_1234 -> rf_wdata=0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
- lh at off=2 with rdata=0x8001_7FFF -> 0xFFFF_8001. lhu at off=0 -> 0x0000_7FFF.
- Load followed by a 3-cycle stall (stall[3]=Stop, stall[4]=Stop), rdata=0xDEAD_BEEF in the first cycle then changed to 0x1111_1111 -> rf_wdata stays 0xDEAD_BEEF for all stalled cycles. On release the next load reads fresh rdata.
- stall[3]=Stop with stall[4]=NoStop -> bubble: next cycle rf_we=0, hilo_bus=0, pc=0.
- ALU instruction (sel_rf_res=0, ex_result=0x0000_002A, rf_waddr=5, rf_we=1) -> mem_to_rf_bus = {1, 5, 0x2A} one cycle later; hilo_bus {1,1,0x1,0x2} passes unchanged.
